// File: rtl/reservation_station.sv
// Tomasulo reservation station: a compacting queue of DEPTH entries that snoops
// the CDB for pending source tags and dispatches the oldest ready entry.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int OP_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [TAG_W-1:0] issue_dest,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic [31:0]      issue_a,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OP_W-1:0]  ex_op,
    output logic [TAG_W-1:0] ex_dest,
    output logic [31:0]      ex_vj,
    output logic [31:0]      ex_vk,
    output logic [31:0]      ex_a,
    output logic [3:0]       count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OP_W-1:0]  op_q   [DEPTH];
    logic [OP_W-1:0]  op_d   [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [TAG_W-1:0] qj_d   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [TAG_W-1:0] qk_d   [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [31:0]      vj_d   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [31:0]      vk_d   [DEPTH];
    logic [31:0]      a_q    [DEPTH];
    logic [31:0]      a_d    [DEPTH];
    logic [3:0]       count_q;
    logic [3:0]       count_d;

    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] src;
    logic [3:0]       wr_idx;
    logic             any_ready;
    logic             kill;
    logic             issue_fire;
    logic             dispatch_fire;

    assign kill = reset || flush;

    // Readiness uses stored tags only, so a CDB wake-up dispatches a cycle later.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (4'(i) < count_q) && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel       = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    // Valid/ready: a transfer happens on any cycle where both are high; ex_valid
    // only drops without a transfer when the station is being cleared.
    assign ex_valid      = any_ready && !kill;
    assign ex_op         = op_q[sel];
    assign ex_dest       = dest_q[sel];
    assign ex_vj         = vj_q[sel];
    assign ex_vk         = vk_q[sel];
    assign ex_a          = a_q[sel];
    assign issue_ready   = (count_q != 4'(DEPTH));
    assign count         = count_q;
    assign issue_fire    = issue_valid && issue_ready && !kill;
    assign dispatch_fire = ex_valid && ex_ready;

    always_comb begin
        count_d = count_q + {3'b000, issue_fire} - {3'b000, dispatch_fire};
        wr_idx  = count_q - {3'b000, dispatch_fire};
        src     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            src = IDX_W'(i);
            if (dispatch_fire && (IDX_W'(i) >= sel) && (i < DEPTH - 1)) begin
                src = IDX_W'(i + 1);
            end
            op_d[i]   = op_q[src];
            dest_d[i] = dest_q[src];
            qj_d[i]   = qj_q[src];
            qk_d[i]   = qk_q[src];
            vj_d[i]   = vj_q[src];
            vk_d[i]   = vk_q[src];
            a_d[i]    = a_q[src];
            if (issue_fire && (4'(i) == wr_idx)) begin
                op_d[i]   = issue_op;
                dest_d[i] = issue_dest;
                qj_d[i]   = issue_qj;
                qk_d[i]   = issue_qk;
                vj_d[i]   = issue_vj;
                vk_d[i]   = issue_vk;
                a_d[i]    = issue_a;
            end
            // Snooping after the shift/write also covers the issue-time bypass.
            if (cdb_valid && (qj_d[i] != '0) && (qj_d[i] == cdb_tag)) begin
                vj_d[i] = cdb_data;
                qj_d[i] = '0;
            end
            if (cdb_valid && (qk_d[i] != '0) && (qk_d[i] == cdb_tag)) begin
                vk_d[i] = cdb_data;
                qk_d[i] = '0;
            end
        end
        if (kill) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= op_d[i];
            dest_q[i] <= dest_d[i];
            qj_q[i]   <= qj_d[i];
            qk_q[i]   <= qk_d[i];
            vj_q[i]   <= vj_d[i];
            vk_q[i]   <= vk_d[i];
            a_q[i]    <= a_d[i];
        end
    end

endmodule
